avalon_clint: RTL and testbench
===============================

# avalon_clint

Memory-mapped core-local interruptor that answers the core's data-bus Avalon-MM requests as a responder. It holds the 64-bit machine timer (`mtime`), the timer compare (`mtimecmp`) and the software-interrupt bit (`msip`). It drives the `timer_interrupt` and `software_interrupt` inputs of the core. It sits on the dbus fabric beside data memory, selected by the bus decoder.

## Interface
- `PRESCALE`, default 1: clock cycles per `mtime` increment; legal range 1..65535; used only when `CLINT_PRESCALE_EN` is defined.
- `clk` input 1: single clock.
- `rst` input 1: reset, asynchronous, active-low.
- `clint_avalon_req` input `avalon_req_t`: fields used are `read`, `write`, `address[31:0]`, `writedata[31:0]` and `byte_enable[3:0]`.
- `clint_avalon_resp` output `avalon_resp_t`: fields driven are `readdata[31:0]` and `waitrequest`.
- `software_interrupt` output 1: equals `msip[0]`.
- `timer_interrupt` output 1: registered result of `mtime >= mtimecmp`.

## Operation
- Address decode uses `address[15:0]` only; upper bits are ignored because the fabric has already selected the block.
- Register map:
  - 0x0000 `msip`: bit 0 is read/write; bits 31:1 read 0.
  - 0x4000 `mtimecmp[31:0]`.
  - 0x4004 `mtimecmp[63:32]`.
  - 0xBFF8 `mtime[31:0]`.
  - 0xBFFC `mtime[63:32]`.
- Unmapped offsets, and any offset with `address[1:0]` != 0: reads return 0; writes are ignored; no error is signalled.
- Writes honor `byte_enable` per byte lane. The write takes effect at the clock edge where `write`=1.
- `read` and `write` asserted together: the write is performed, and `readdata` returns the pre-write value.
- Read/write request handling: `waitrequest` is constant 0, so every request is accepted in the cycle it is presented.
- `mtime` update:
  - Increments by 1 on each tick and wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
  - A write to either `mtime` half in the same cycle as a tick wins: the written bytes are loaded, and the unwritten bytes keep their old value without the increment.
  - A carry from the low word into the high word is applied in the same cycle as the low-word increment.
- The two 32-bit halves are not atomic. Software updates `mtimecmp` by writing 0xFFFF_FFFF to the high word first; the block does not enforce this.
- `timer_interrupt` is level-sensitive and stays high while `mtime >= mtimecmp` (64-bit unsigned compare). It clears only through a write to `mtimecmp` or `mtime`.
- Prescaler: a 16-bit counter runs from 0 to `PRESCALE`-1 and generates one tick when it wraps (macro enabled only).

## Timing
- Reset values:
  - `mtime` = 0 and `mtimecmp` = 0xFFFF_FFFF_FFFF_FFFF.
  - `msip` = 0 and the prescaler counter = 0.
  - `timer_interrupt` = 0 and `software_interrupt` = 0.
  - `readdata` = 0 and `waitrequest` = 0.
- Reset asserted mid-operation clears all state immediately (asynchronous); no request in flight survives.
- Read latency is 1 cycle. `readdata` is registered from the request at edge N and is valid in cycle N+1. It holds its value until the next read.
- Write to `msip`: `software_interrupt` changes 1 cycle after the write edge.
- Compare path: `timer_interrupt` reflects the state after edge N at edge N+1.
  - It rises 1 cycle after `mtime` first equals `mtimecmp`.
  - It falls 1 cycle after the register write that breaks the condition.
- A read of `mtime` returns the value before the increment in the same edge.

## Configuration
- `CLINT_PRESCALE_EN`:
  - Defined: `mtime` increments once every `PRESCALE` clocks. `PRESCALE`=1 behaves identically to the undefined case.
  - Undefined: `mtime` increments every clock, and the prescaler counter is not synthesized.

## Test plan
- Reset release, then read 0xBFF8 at the first cycle and again 10 cycles later -> `readdata` = 0 and then 10 (macro off). `timer_interrupt` stays 0.
- Write 0x4004=0 and 0x4000=20 -> `timer_interrupt` rises exactly 1 cycle after `mtime`=20. Then write 0x4000=0xFFFF_FFFF and 0x4004=0xFFFF_FFFF -> `timer_interrupt` falls 1 cycle after the write.
- Write 0x0000=0x1 with `byte_enable`=0x1 -> `software_interrupt`=1 the next cycle. Write 0x0000=0x1 with `byte_enable`=0x2 -> no change. Write 0x0000=0 -> `software_interrupt`=0.
- Write 0xBFF8=0xFFFF_FFFE and 0xBFFC=0 -> 2 cycles later `mtime`=0x1_0000_0000 (carry into the high word). Write both halves to 0xFFFF_FFFF -> next tick gives `mtime`=0 (wrap).
- Read 0x1234, and read 0x4002 -> `readdata`=0. Write 0x1234 -> no register changes.
- Macro on with `PRESCALE`=4 -> `mtime` reads 0, 0, 0, 0, 1 across 5 consecutive cycles. A write to 0xBFF8 in the same cycle as a tick -> the written value is loaded without increment.

Source files
------------

// File: rtl/avalon_clint.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// avalon_clint -- core-local interruptor on the Avalon-MM data bus
//
// Holds the 64-bit machine timer (mtime), the timer compare (mtimecmp) and the
// software-interrupt bit (msip). Drives the core's timer and software interrupt
// inputs.
//
// Register map (address[15:0], word aligned only):
//   0x0000  msip          bit 0 r/w, bits 31:1 read 0
//   0x4000  mtimecmp[31:0]
//   0x4004  mtimecmp[63:32]
//   0xBFF8  mtime[31:0]
//   0xBFFC  mtime[63:32]
// Anything else reads 0 and ignores writes.
//
// Ports:
//   clk                 single clock
//   rst                 asynchronous reset, active low
//   clint_avalon_req    Avalon-MM request (read, write, address, writedata,
//                       byte_enable)
//   clint_avalon_resp   Avalon-MM response (readdata registered, 1-cycle read
//                       latency; waitrequest tied 0)
//   software_interrupt  msip[0]
//   timer_interrupt     registered (mtime >= mtimecmp)
//
// Parameter PRESCALE (1..65535): clocks per mtime increment, only effective
// when the macro CLINT_PRESCALE_EN is defined. Without the macro mtime counts
// every clock and no prescaler counter exists.
// -----------------------------------------------------------------------------
package avalon_clint_pkg;
   typedef struct packed {
      logic        read;
      logic        write;
      logic [31:0] address;
      logic [31:0] writedata;
      logic [3:0]  byte_enable;
   } avalon_req_t;

   typedef struct packed {
      logic [31:0] readdata;
      logic        waitrequest;
   } avalon_resp_t;
endpackage

module avalon_clint
   import avalon_clint_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  avalon_req_t  clint_avalon_req,
   output avalon_resp_t clint_avalon_resp,
   output logic         software_interrupt,
   output logic         timer_interrupt
);

   if ((PRESCALE == 0) || (PRESCALE > 65535)) begin : g_prescale_range
      $error("avalon_clint: PRESCALE must be in 1..65535");
   end

   localparam logic [15:0] OFF_MSIP     = 16'h0000;
   localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
   localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
   localparam logic [15:0] OFF_MTIME_LO = 16'hBFF8;
   localparam logic [15:0] OFF_MTIME_HI = 16'hBFFC;

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        msip_q, msip_d;
   logic [31:0] rdata_q, rdata_d;
   logic        tirq_q, tirq_d;
   logic        tick;

   logic [15:0] offset;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        wr_en;
   logic        wr_mtime;
   logic [31:0] rd_mux;

   // The fabric has already selected this block, so the upper address half
   // carries no information here.
   logic unused_addr_hi;
   assign unused_addr_hi = ^clint_avalon_req.address[31:16];

   assign offset = clint_avalon_req.address[15:0];
   assign wdata  = clint_avalon_req.writedata;
   assign be     = clint_avalon_req.byte_enable;
   assign wr_en  = clint_avalon_req.write;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_v;
      for (int i = 0; i < 4; i++) begin
         if (lanes[i]) res[8*i +: 8] = new_v[8*i +: 8];
      end
      return res;
   endfunction

`ifdef CLINT_PRESCALE_EN
   localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE - 1);

   logic [15:0] presc_q, presc_d;

   always_comb begin
      tick    = (presc_q == PRESCALE_LAST);
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) presc_q <= 16'd0;
      else      presc_q <= presc_d;
   end
`else
   assign tick = 1'b1;
`endif

   always_comb begin
      rd_mux = 32'd0;
      case (offset)
         OFF_MSIP:     rd_mux = {31'd0, msip_q};
         OFF_CMP_LO:   rd_mux = mtimecmp_q[31:0];
         OFF_CMP_HI:   rd_mux = mtimecmp_q[63:32];
         OFF_MTIME_LO: rd_mux = mtime_q[31:0];
         OFF_MTIME_HI: rd_mux = mtime_q[63:32];
         default:      rd_mux = 32'd0;
      endcase
   end

   assign wr_mtime = wr_en && ((offset == OFF_MTIME_LO) || (offset == OFF_MTIME_HI));

   always_comb begin
      mtime_d    = mtime_q;
      mtimecmp_d = mtimecmp_q;
      msip_d     = msip_q;
      rdata_d    = rdata_q;
      // Compare uses the state before this edge, so the flag trails the
      // register state by one cycle.
      tirq_d     = (mtime_q >= mtimecmp_q);

      // Read data comes from pre-write values, which also covers read+write.
      if (clint_avalon_req.read) rdata_d = rd_mux;

      if (wr_en) begin
         case (offset)
            OFF_MSIP:     if (be[0]) msip_d = wdata[0];
            OFF_CMP_LO:   mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0],  wdata, be);
            OFF_CMP_HI:   mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wdata, be);
            OFF_MTIME_LO: mtime_d[31:0]     = merge_bytes(mtime_q[31:0],     wdata, be);
            OFF_MTIME_HI: mtime_d[63:32]    = merge_bytes(mtime_q[63:32],    wdata, be);
            default:      ;
         endcase
      end

      // A software write to either half suppresses the whole increment.
      if (tick && !wr_mtime) mtime_d = mtime_q + 64'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mtime_q    <= 64'd0;
         mtimecmp_q <= '1;
         msip_q     <= 1'b0;
         rdata_q    <= 32'd0;
         tirq_q     <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         mtimecmp_q <= mtimecmp_d;
         msip_q     <= msip_d;
         rdata_q    <= rdata_d;
         tirq_q     <= tirq_d;
      end
   end

   always_comb begin
      clint_avalon_resp.readdata    = rdata_q;
      clint_avalon_resp.waitrequest = 1'b0;
   end

   assign software_interrupt = msip_q;
   assign timer_interrupt    = tirq_q;

endmodule

// File: tb/tb_avalon_clint.sv
`timescale 1ns/1ps
module tb_avalon_clint;
   import avalon_clint_pkg::*;

`ifdef CLINT_PRESCALE_EN
   localparam int PS = 4;
`else
   localparam int PS = 1;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   avalon_req_t  req;
   avalon_resp_t resp;
   logic         sw_irq;
   logic         tm_irq;

   int n_cmp = 0;
   int n_mis = 0;

   // reference model state
   logic [63:0] m_mtime;
   logic [63:0] m_cmp;
   logic        m_msip;
   logic [31:0] m_rd;
   logic        m_tirq;
   int          m_edges;

   logic [15:0] offs [7] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8,
                             16'hBFFC, 16'h1234, 16'h4002};
   logic [31:0] r_rand, r_addr, r_wd;
   logic [15:0] r_off;
   int          r_sel;

   avalon_clint #(.PRESCALE(PS)) dut (
      .clk                (clk),
      .rst                (rst),
      .clint_avalon_req   (req),
      .clint_avalon_resp  (resp),
      .software_interrupt (sw_irq),
      .timer_interrupt    (tm_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      case (a[15:0])
         16'h0000: return {31'd0, m_msip};
         16'h4000: return m_cmp[31:0];
         16'h4004: return m_cmp[63:32];
         16'hBFF8: return m_mtime[31:0];
         16'hBFFC: return m_mtime[63:32];
         default:  return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_mtime = 64'd0;
      m_cmp   = '1;
      m_msip  = 1'b0;
      m_rd    = 32'd0;
      m_tirq  = 1'b0;
      m_edges = 0;
   endtask

   // One clock edge of the register map's behaviour, from the pre-edge state.
   task automatic model_edge(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] mask;
      logic        inc;
      mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      m_edges++;
      inc    = ((m_edges % PS) == 0);
      m_tirq = (m_mtime >= m_cmp);
      if (rd) m_rd = model_read(a);
      if (wr) begin
         case (a[15:0])
            16'h0000: if (be[0]) m_msip = wd[0];
            16'h4000: m_cmp[31:0]    = (m_cmp[31:0]    & ~mask) | (wd & mask);
            16'h4004: m_cmp[63:32]   = (m_cmp[63:32]   & ~mask) | (wd & mask);
            16'hBFF8: begin m_mtime[31:0]  = (m_mtime[31:0]  & ~mask) | (wd & mask); inc = 1'b0; end
            16'hBFFC: begin m_mtime[63:32] = (m_mtime[63:32] & ~mask) | (wd & mask); inc = 1'b0; end
            default: ;
         endcase
      end
      if (inc) m_mtime = m_mtime + 64'd1;
   endtask

   task automatic do_cycle(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
      req.read        = rd;
      req.write       = wr;
      req.address     = a;
      req.writedata   = wd;
      req.byte_enable = be;
      @(posedge clk);
      model_edge(rd, wr, a, wd, be);
      #1;
      check("readdata",    64'(resp.readdata),    64'(m_rd));
      check("waitrequest", 64'(resp.waitrequest), 64'd0);
      check("timer_irq",   64'(tm_irq),           64'(m_tirq));
      check("sw_irq",      64'(sw_irq),           64'(m_msip));
      req.read  = 1'b0;
      req.write = 1'b0;
   endtask

   task automatic idle();
      do_cycle(1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
   endtask

   task automatic bus_rd(input logic [31:0] a);
      do_cycle(1'b1, 1'b0, a, 32'd0, 4'd0);
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
      do_cycle(1'b0, 1'b1, a, wd, be);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      req = '0;
      model_reset();
      #3;
      check("rst_readdata", 64'(resp.readdata),    64'd0);
      check("rst_waitreq",  64'(resp.waitrequest), 64'd0);
      check("rst_tirq",     64'(tm_irq),           64'd0);
      check("rst_swirq",    64'(sw_irq),           64'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();

      // mtime counting from reset
      bus_rd(32'h0000_BFF8);
      check("mtime_first", 64'(resp.readdata), 64'd0);
      repeat (9) idle();
      bus_rd(32'h0000_BFF8);
      check("mtime_10", 64'(resp.readdata), 64'(10 / PS));
      check("tirq_quiet", 64'(tm_irq), 64'd0);

      // timer interrupt rise and fall
      bus_wr(32'h0000_4004, 32'd0, 4'hF);
      bus_wr(32'h0000_4000, 32'd20, 4'hF);
      for (int i = 0; i < 400 && m_mtime != 64'd20; i++) idle();
      if (m_mtime != 64'd20) begin
         n_cmp++;
         n_mis++;
         $error("FAIL cmp_wait: observed 0x%0h expected 0x14", m_mtime);
      end
      check("tirq_pre_rise", 64'(tm_irq), 64'd0);
      idle();
      check("tirq_rise", 64'(tm_irq), 64'd1);
      bus_wr(32'h0000_4000, 32'hFFFF_FFFF, 4'hF);
      check("tirq_hold", 64'(tm_irq), 64'd1);
      bus_wr(32'h0000_4004, 32'hFFFF_FFFF, 4'hF);
      check("tirq_fall", 64'(tm_irq), 64'd0);

      // software interrupt with byte lanes
      bus_wr(32'h0000_0000, 32'h1, 4'h1);
      check("msip_set", 64'(sw_irq), 64'd1);
      bus_wr(32'h0000_0000, 32'h1, 4'h2);
      check("msip_lane1", 64'(sw_irq), 64'd1);
      bus_rd(32'h0000_0000);
      check("msip_read", 64'(resp.readdata), 64'd1);
      bus_wr(32'h0000_0000, 32'h0, 4'hF);
      check("msip_clr", 64'(sw_irq), 64'd0);

      // carry and wrap
      bus_wr(32'h0000_BFF8, 32'hFFFF_FFFE, 4'hF);
      bus_wr(32'h0000_BFFC, 32'h0, 4'hF);
      idle();
      idle();
      bus_rd(32'h0000_BFFC);
`ifndef CLINT_PRESCALE_EN
      check("carry_hi", 64'(resp.readdata), 64'd1);
`endif
      bus_wr(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF);
      bus_wr(32'hA5A5_BFFC, 32'hFFFF_FFFF, 4'hF);
      bus_rd(32'h0000_BFF8);
      check("wrap_pre", 64'(resp.readdata), 64'hFFFF_FFFF);
      for (int i = 0; i < 8; i++) bus_rd(32'h0000_BFFC);
`ifndef CLINT_PRESCALE_EN
      check("wrap_hi", 64'(resp.readdata), 64'd0);
`endif

      // unmapped and misaligned offsets
      bus_rd(32'h0000_1234);
      check("unmapped_rd", 64'(resp.readdata), 64'd0);
      bus_rd(32'hFFFF_4002);
      check("misaligned_rd", 64'(resp.readdata), 64'd0);
      bus_wr(32'h0000_1234, 32'hDEAD_BEEF, 4'hF);
      bus_rd(32'h0000_4000);
      check("unmapped_wr_cmp", 64'(resp.readdata), 64'hFFFF_FFFF);
      bus_rd(32'h0000_0000);
      check("unmapped_wr_msip", 64'(resp.readdata), 64'd0);

      // read and write together returns the old value
      do_cycle(1'b1, 1'b1, 32'h0000_4000, 32'h1234_5678, 4'hF);
      check("rdwr_old", 64'(resp.readdata), 64'hFFFF_FFFF);
      bus_rd(32'h0000_4000);
      check("rdwr_new", 64'(resp.readdata), 64'h1234_5678);
      bus_wr(32'h0000_4000, 32'hFFFF_FFFF, 4'hF);

`ifdef CLINT_PRESCALE_EN
      apply_reset();
      for (int k = 0; k < 5; k++) begin
         bus_rd(32'h0000_BFF8);
         check("presc_seq", 64'(resp.readdata), (k == 4) ? 64'd1 : 64'd0);
      end
`endif

      // write to mtime in the same cycle as a tick loads without increment
      for (int i = 0; i < 16 && ((m_edges + 1) % PS) != 0; i++) idle();
      bus_wr(32'h0000_BFF8, 32'h0000_0100, 4'hF);
      bus_rd(32'h0000_BFF8);
      check("tick_collide", 64'(resp.readdata), 64'h100);

      // asynchronous reset mid-operation
      bus_wr(32'h0000_0000, 32'h1, 4'h1);
      bus_wr(32'h0000_4004, 32'h0, 4'hF);
      bus_wr(32'h0000_4000, 32'h0, 4'hF);
      bus_rd(32'h0000_BFF8);
      idle();
      check("pre_async_tirq", 64'(tm_irq), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      check("async_readdata", 64'(resp.readdata), 64'd0);
      check("async_tirq",     64'(tm_irq),        64'd0);
      check("async_swirq",    64'(sw_irq),        64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      bus_rd(32'h0000_4004);
      check("post_rst_cmp_hi", 64'(resp.readdata), 64'hFFFF_FFFF);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         r_sel  = int'($urandom_range(0, 7));
         r_rand = $urandom();
         r_off  = (r_sel == 7) ? r_rand[15:0] : offs[r_sel];
         r_addr = {r_rand[31:16], r_off};
         r_wd   = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 64));
         do_cycle($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                  r_addr, r_wd, 4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
